// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
// Imported by the detector top and its history sub-module.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/seq_det_history.sv
// Serial history shift register with a fill counter saturating at len.
// full reports the fill level as it stands after this cycle's shift.
module seq_det_history
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic [LEN_W-1:0]   len,
  output logic [MAX_LEN-1:0] history,
  output logic               full
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + LEN_W'(1);

  // Lookahead so the caller can act on the bit that completes the fill.
  assign full = shift_en ? (cnt_inc >= len) : (cnt_q >= len);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      history <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      history <= '0;
      cnt_q   <= '0;
    end else if (shift_en) begin
      history <= {history[MAX_LEN-2:0], bit_in};
      if (cnt_q < len)
        cnt_q <= cnt_inc;
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector: runtime pattern, length and
// overlap mode, registered match pulse and saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int  MAX_LEN = MAX_LEN_DEF,
  parameter int  CNT_W   = CNT_W_DEF,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               count_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy
);

  state_t state_q;
  state_t state_d;

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ov_q;

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] mask;
  logic               full;
  logic               cfg_ok;
  logic [LEN_W-1:0]   len_clamp;
  logic               shift_en;
  logic               hit;
  logic               h_clear;

  assign cfg_ok    = cfg_we & (cfg_len != '0);
  assign len_clamp = (cfg_len > LEN_W'(MAX_LEN)) ?
                     LEN_W'(MAX_LEN) : cfg_len;
  assign shift_en  = din_valid & ~cfg_we & (state_q != IDLE);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (LEN_W'(i) < len_q);
  end

  // Old history bits [len-2:0] plus the incoming bit form the window.
  assign hit = shift_en & full & (din == pat_q[0]) &
               (((hist ^ (pat_q >> 1)) & (mask >> 1)) == '0);

  assign h_clear = cfg_we | (hit & ~ov_q);

  seq_det_history #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (h_clear),
    .shift_en (shift_en),
    .bit_in   (din),
    .len      (len_q),
    .history  (hist),
    .full     (full)
  );

  always_comb begin
    state_d = state_q;
    if (cfg_we) begin
      state_d = cfg_ok ? FILL : IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        FILL: begin
          if (hit & ~ov_q)
            state_d = FILL;
          else if (shift_en & full)
            state_d = ARMED;
        end
        ARMED: begin
          if (hit & ~ov_q)
            state_d = FILL;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // A rejected (zero-length) write keeps the old pattern.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pat_q <= '0;
      len_q <= '0;
      ov_q  <= 1'b0;
    end else if (cfg_ok) begin
      pat_q <= cfg_pattern;
      len_q <= len_clamp;
      ov_q  <= cfg_overlap;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      z           <= 1'b0;
      match_count <= '0;
    end else begin
      z <= hit;
      if (count_clr)
        match_count <= '0;
      else if (hit && (match_count != '1))
        match_count <= match_count + CNT_W'(1);
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench: reference model predicts z/count/busy per cycle,
// monitor compares after each rising edge.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       din_valid;
  logic       din;
  logic       count_clr;

  logic       z_a, z_b, busy_a, busy_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  seq_detector_prog u_a (
    .clk (clk), .reset_n (reset_n), .cfg_we (cfg_we),
    .cfg_pattern (cfg_pattern), .cfg_len (cfg_len),
    .cfg_overlap (cfg_overlap), .din_valid (din_valid), .din (din),
    .count_clr (count_clr), .z (z_a), .match_count (cnt_a),
    .busy (busy_a)
  );

  seq_detector_prog #(.MAX_LEN (8), .CNT_W (2)) u_b (
    .clk (clk), .reset_n (reset_n), .cfg_we (cfg_we),
    .cfg_pattern (cfg_pattern), .cfg_len (cfg_len),
    .cfg_overlap (cfg_overlap), .din_valid (din_valid), .din (din),
    .count_clr (count_clr), .z (z_b), .match_count (cnt_b),
    .busy (busy_b)
  );

  typedef struct {
    bit z;
    int c8;
    int c2;
    bit busy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: a window of bits received since last clear.
  bit       m_cfg = 0;
  bit [7:0] m_pat = 0;
  int       m_len = 0;
  bit       m_ov = 0;
  bit       m_bits[$];
  int       m_c8 = 0;
  int       m_c2 = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_step();
    bit m = 0;
    if (!reset_n) begin
      m_cfg = 0; m_pat = 0; m_len = 0; m_ov = 0;
      m_bits.delete(); m_c8 = 0; m_c2 = 0;
    end else begin
      if (cfg_we) begin
        m_bits.delete();
        if (cfg_len == 0) begin
          m_cfg = 0;
        end else begin
          m_cfg = 1;
          m_pat = cfg_pattern;
          m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
          m_ov  = cfg_overlap;
        end
      end else if (din_valid && m_cfg) begin
        m_bits.push_back(din);
        if (m_bits.size() > m_len) void'(m_bits.pop_front());
        if (m_bits.size() == m_len) begin
          m = 1;
          for (int i = 0; i < m_len; i++)
            if (m_bits[i] != m_pat[m_len-1-i]) m = 0;
          if (m && !m_ov) m_bits.delete();
        end
      end
      if (count_clr) begin
        m_c8 = 0; m_c2 = 0;
      end else if (m) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
    q.push_back('{m, m_c8, m_c2, m_cfg});
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("z_a", 32'(z_a), 32'(mon_e.z));
      chk("z_b", 32'(z_b), 32'(mon_e.z));
      chk("count_a", 32'(cnt_a), 32'(mon_e.c8));
      chk("count_b", 32'(cnt_b), 32'(mon_e.c2));
      chk("busy", 32'(busy_a), 32'(mon_e.busy));
    end
  end

  task automatic step(bit rn, bit we, logic [7:0] p, logic [3:0] l,
                      bit ov, bit dv, bit d, bit clr);
    @(negedge clk);
    reset_n = rn; cfg_we = we; cfg_pattern = p; cfg_len = l;
    cfg_overlap = ov; din_valid = dv; din = d; count_clr = clr;
    model_step();
  endtask

  task automatic cfg(logic [7:0] p, logic [3:0] l, bit ov);
    step(1, 1, p, l, ov, 0, 0, 0);
  endtask

  task automatic send(bit d);
    step(1, 0, 8'h00, 4'd0, 0, 1, d, 0);
  endtask

  task automatic idle();
    step(1, 0, 8'h00, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic clr();
    step(1, 0, 8'h00, 4'd0, 0, 0, 0, 1);
  endtask

  task automatic send_bits(logic [31:0] v, int n);
    for (int i = n - 1; i >= 0; i--) send(v[i]);
  endtask

  task automatic dchk(string nm, int act, int expv);
    @(negedge clk);
    chk(nm, 32'(act), 32'(expv));
  endtask

  initial begin
    reset_n = 0; cfg_we = 0; cfg_pattern = 0; cfg_len = 0;
    cfg_overlap = 0; din_valid = 0; din = 0; count_clr = 0;
    step(0, 0, 8'h00, 4'd0, 0, 1, 1, 0);
    step(0, 1, 8'hFF, 4'd3, 1, 1, 1, 0);
    idle();

    cfg(8'b1011, 4'd4, 1);
    send_bits(32'b1011011, 7);
    idle();
    dchk("overlap_count", int'(cnt_a), 2);

    clr();
    cfg(8'b1011, 4'd4, 0);
    send_bits(32'b1011011, 7);
    idle();
    dchk("nonoverlap_count", int'(cnt_a), 1);
    clr();
    cfg(8'b1011, 4'd4, 0);
    send_bits(32'b10111011, 8);
    idle();
    dchk("nonoverlap_8bit_count", int'(cnt_a), 2);

    clr();
    cfg(8'b1011, 4'd4, 1);
    for (int i = 3; i >= 0; i--) begin
      send(i != 2);
      repeat (3) idle();
    end
    dchk("gap_count", int'(cnt_a), 1);

    clr();
    cfg(8'b1011, 4'd4, 1);
    send_bits(32'b101, 3);
    step(1, 1, 8'b110, 4'd3, 1, 1, 1, 0);
    send_bits(32'b110, 3);
    idle();
    dchk("reconfig_count", int'(cnt_a), 1);

    clr();
    cfg(8'b1, 4'd1, 1);
    repeat (8) send(1);
    idle();
    dchk("sat_count", int'(cnt_b), 3);
    step(1, 0, 8'h00, 4'd0, 0, 1, 1, 1);
    idle();
    dchk("clr_over_inc", int'(cnt_b), 0);
    send(1); send(1);
    step(0, 0, 8'h00, 4'd0, 0, 1, 1, 0);
    repeat (3) send(1);
    dchk("reset_busy", int'(busy_a), 0);

    cfg(8'b1, 4'd0, 1);
    repeat (5) send(1);
    repeat (5) send(0);
    dchk("len0_busy", int'(busy_a), 0);
    cfg(8'hA5, 4'd15, 1);
    send_bits(32'hA5A5, 16);
    idle();
    dchk("clamp_count", int'(cnt_a), 2);

    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0)
        step(0, 0, 8'h00, 4'd0, 0, 1, 1, 0);
      else if (r < 6)
        step(1, 1, 8'($urandom),
             4'((r == 5) ? $urandom_range(0, 15) : $urandom_range(1, 4)),
             1'($urandom), 1'($urandom), 1'($urandom), 0);
      else
        step(1, 0, 8'h00, 4'd0, 0, ($urandom_range(0, 9) < 7),
             1'($urandom), ($urandom_range(0, 99) < 2));
    end

    repeat (3) idle();
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
